// File: rtl/fifo_nway.sv
// ---------------------------------------------------------------------------
// fifo_nway
//   N-way synchronous FIFO. Up to WAYS entries can be pushed and up to WAYS
//   entries can be popped on every rising edge. Reads are first-word
//   fall-through: an entry pushed at edge N is visible on data_out after N.
//
// Optional feature macro: FIFO_NWAY_FLUSH_EN
//   When it is defined, a synchronous flush input empties the FIFO. Reset
//   takes priority over flush.
//
// Parameters
//   WIDTH  data bits per lane
//   DEPTH  number of entries; must be a power of two and >= 2*WAYS
//   WAYS   lanes on each side, >= 1
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high
//   flush      synchronous empty (present only with FIFO_NWAY_FLUSH_EN)
//   data_in    producer lanes, lane i = data_in[i*WIDTH +: WIDTH]
//   valid_in   producer lane valids (thermometer from lane 0)
//   able_in    lane i may push this cycle (thermometer)
//   data_out   lane i = entry at head+i, zero when that lane is not valid
//   valid_out  lane i holds a valid entry (thermometer)
//   ready_out  consumer accepts lane i (thermometer)
//   count      current occupancy, 0..DEPTH
//
// Handshake: lane i of the write side transfers on an edge when valid_in[i]
// and able_in[i] are both high, and so do all lanes below it. Lane i of the
// read side transfers when ready_out[i] and valid_out[i] are both high, and
// so do all lanes below it. The first lane that does not transfer ends the
// transfer for that side, so higher lanes are ignored even when both high.
// ---------------------------------------------------------------------------
module fifo_nway #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int WAYS  = 3
) (
  input  logic                         clk,
  input  logic                         reset,
`ifdef FIFO_NWAY_FLUSH_EN
  input  logic                         flush,
`endif
  input  logic [WAYS*WIDTH-1:0]        data_in,
  input  logic [WAYS-1:0]              valid_in,
  output logic [WAYS-1:0]              able_in,
  output logic [WAYS*WIDTH-1:0]        data_out,
  output logic [WAYS-1:0]              valid_out,
  input  logic [WAYS-1:0]              ready_out,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int NW = $clog2(WAYS+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic [NW-1:0]    push_n;
  logic [NW-1:0]    pop_n;
  logic             clr;

  // Length of the unbroken run of ones starting at lane 0.
  function automatic logic [NW-1:0] run_len(input logic [WAYS-1:0] v);
    logic [NW-1:0] n;
    logic          run;
    n   = '0;
    run = 1'b1;
    for (int i = 0; i < WAYS; i++) begin
      run = run & v[i];
      if (run) n = n + NW'(1);
    end
    return n;
  endfunction

`ifdef FIFO_NWAY_FLUSH_EN
  assign clr = reset | flush;
`else
  assign clr = reset;
`endif

  assign count = count_q;

  // Lane status comes from the registered count only: a pop in the same
  // cycle never frees space for a push, which keeps able_in off the
  // consumer's combinational path.
  always_comb begin
    able_in   = '0;
    valid_out = '0;
    data_out  = '0;
    for (int i = 0; i < WAYS; i++) begin
      able_in[i]  = (DEPTH - int'(count_q)) > i;
      valid_out[i] = int'(count_q) > i;
      if (valid_out[i]) data_out[i*WIDTH +: WIDTH] = mem[rd_ptr + PW'(i)];
    end
  end

  always_comb begin
    push_n = run_len(valid_in & able_in);
    pop_n  = run_len(ready_out & valid_out);
  end

  // Storage is not reset; pointers and count alone define what is valid.
  // Writes are suppressed on a clearing edge so that push is discarded.
  always_ff @(posedge clk) begin
    if (!clr) begin
      for (int k = 0; k < WAYS; k++) begin
        if (k < int'(push_n)) mem[wr_ptr + PW'(k)] <= data_in[k*WIDTH +: WIDTH];
      end
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      wr_ptr  <= wr_ptr + PW'(push_n);
      rd_ptr  <= rd_ptr + PW'(pop_n);
      count_q <= count_q + CW'(push_n) - CW'(pop_n);
    end
  end

endmodule

// File: tb/tb_fifo_nway.sv
// ---------------------------------------------------------------------------
// tb_fifo_nway
//   Self-checking bench for fifo_nway (WIDTH=8, DEPTH=16, WAYS=3).
//   Reference model: a queue of data words holding the FIFO contents in
//   order. Every cycle the DUT outputs are compared with what the queue
//   implies, and every popped word is compared with an independent running
//   sequence number (pushed data is a strictly incrementing counter).
// ---------------------------------------------------------------------------
module tb_fifo_nway;
  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int WAYS  = 3;
  localparam int CW    = $clog2(DEPTH+1);

  // ---- clock / reset ------------------------------------------------------
  logic                  clk = 1'b0;
  logic                  reset;
  logic [WAYS*WIDTH-1:0] data_in;
  logic [WAYS-1:0]       valid_in;
  logic [WAYS-1:0]       able_in;
  logic [WAYS*WIDTH-1:0] data_out;
  logic [WAYS-1:0]       valid_out;
  logic [WAYS-1:0]       ready_out;
  logic [CW-1:0]         count;
`ifdef FIFO_NWAY_FLUSH_EN
  logic                  flush;
`endif

  always #5 clk = ~clk;

  fifo_nway #(.WIDTH(WIDTH), .DEPTH(DEPTH), .WAYS(WAYS)) dut (
    .clk       (clk),
    .reset     (reset),
`ifdef FIFO_NWAY_FLUSH_EN
    .flush     (flush),
`endif
    .data_in   (data_in),
    .valid_in  (valid_in),
    .able_in   (able_in),
    .data_out  (data_out),
    .valid_out (valid_out),
    .ready_out (ready_out),
    .count     (count)
  );

  // ---- scoreboard ---------------------------------------------------------
  int               n_cmp  = 0;
  int               n_fail = 0;
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] next_data;
  logic [WIDTH-1:0] exp_pop_val;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int run_len(input logic [WAYS-1:0] v);
    int n = 0;
    for (int i = 0; i < WAYS; i++) begin
      if (!v[i]) break;
      n++;
    end
    return n;
  endfunction

  function automatic logic [WAYS-1:0] free_mask(input int sz);
    logic [WAYS-1:0] m;
    for (int i = 0; i < WAYS; i++) m[i] = (DEPTH - sz) > i;
    return m;
  endfunction

  function automatic logic [WAYS-1:0] used_mask(input int sz);
    logic [WAYS-1:0] m;
    for (int i = 0; i < WAYS; i++) m[i] = sz > i;
    return m;
  endfunction

  task automatic check_model(input string tag);
    logic [WAYS*WIDTH-1:0] ed;
    int sz;
    sz = exp_q.size();
    ed = '0;
    for (int i = 0; i < WAYS; i++)
      if (i < sz) ed[i*WIDTH +: WIDTH] = exp_q[i];
    check({tag, ".count"},     64'(count),     64'(sz));
    check({tag, ".valid_out"}, 64'(valid_out), 64'(used_mask(sz)));
    check({tag, ".able_in"},   64'(able_in),   64'(free_mask(sz)));
    check({tag, ".data_out"},  64'(data_out),  64'(ed));
  endtask

  // ---- driver tasks -------------------------------------------------------
  // One clock cycle: check current outputs, drive lanes, advance the model.
  task automatic cycle(input logic [WAYS-1:0] vin, input logic [WAYS-1:0] rdy);
    int pn, qn, sz;
    check_model("model");
    sz = exp_q.size();
    for (int i = 0; i < WAYS; i++) data_in[i*WIDTH +: WIDTH] = next_data + WIDTH'(i);
    valid_in  = vin;
    ready_out = rdy;
    pn = run_len(vin & free_mask(sz));
    qn = run_len(rdy & used_mask(sz));
    for (int i = 0; i < qn; i++) begin
      check("pop_order", 64'(data_out[i*WIDTH +: WIDTH]), 64'(exp_pop_val));
      exp_pop_val = exp_pop_val + 1'b1;
      void'(exp_q.pop_front());
    end
    for (int i = 0; i < pn; i++) begin
      exp_q.push_back(next_data);
      next_data = next_data + 1'b1;
    end
    @(posedge clk);
    #1;
    valid_in  = '0;
    ready_out = '0;
  endtask

  // Reset with the given push pattern held, to show reset wins over pushes.
  task automatic do_reset(input logic [WAYS-1:0] vin);
    reset     = 1'b1;
    valid_in  = vin;
    ready_out = '1;
    @(posedge clk);
    #1;
    reset     = 1'b0;
    valid_in  = '0;
    ready_out = '0;
    exp_q.delete();
    exp_pop_val = next_data;
  endtask

  function automatic logic [WAYS-1:0] rand_lanes(input int raw_chance, input int max_n);
    int n;
    if ($urandom_range(0, 99) < raw_chance) return WAYS'($urandom_range(0, (1 << WAYS) - 1));
    n = $urandom_range(0, max_n);
    return WAYS'((1 << n) - 1);
  endfunction

  // ---- vector table -------------------------------------------------------
  typedef struct {
    logic [WAYS-1:0] vin;
    logic [WAYS-1:0] rdy;
    int              exp_count;
    logic [WAYS-1:0] exp_valid;
    logic [WAYS-1:0] exp_able;
  } vec_t;

  vec_t vecs[8];

  // ---- watchdog -----------------------------------------------------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---- main sequence ------------------------------------------------------
  initial begin
    // Applied from empty; expectations after each edge.
    vecs[0] = '{3'b111, 3'b000, 3, 3'b111, 3'b111};
    vecs[1] = '{3'b101, 3'b000, 4, 3'b111, 3'b111};
    vecs[2] = '{3'b000, 3'b111, 1, 3'b001, 3'b111};
    vecs[3] = '{3'b011, 3'b010, 3, 3'b111, 3'b111};
    vecs[4] = '{3'b000, 3'b101, 2, 3'b011, 3'b111};
    vecs[5] = '{3'b000, 3'b111, 0, 3'b000, 3'b111};
    vecs[6] = '{3'b000, 3'b111, 0, 3'b000, 3'b111};
    vecs[7] = '{3'b001, 3'b000, 1, 3'b001, 3'b111};

    reset     = 1'b1;
    valid_in  = '0;
    ready_out = '0;
    data_in   = '0;
`ifdef FIFO_NWAY_FLUSH_EN
    flush     = 1'b0;
`endif
    next_data = 8'd1;
    @(posedge clk);
    #1;
    do_reset('0);

    // Reset state
    check("reset.count",     64'(count),     64'd0);
    check("reset.valid_out", 64'(valid_out), 64'b000);
    check("reset.able_in",   64'(able_in),   64'b111);
    check("reset.data_out",  64'(data_out),  64'd0);

    // Push {3,2,1} with lanes 0..2 = 1,2,3
    cycle(3'b111, 3'b000);
    check("push3.count",     64'(count),     64'd3);
    check("push3.valid_out", 64'(valid_out), 64'b111);
    check("push3.data_out",  64'(data_out),  64'h030201);

    // Table vectors from empty
    do_reset('0);
    foreach (vecs[i]) begin
      cycle(vecs[i].vin, vecs[i].rdy);
      check($sformatf("vec%0d.count", i),     64'(count),     64'(vecs[i].exp_count));
      check($sformatf("vec%0d.valid_out", i), 64'(valid_out), 64'(vecs[i].exp_valid));
      check($sformatf("vec%0d.able_in", i),   64'(able_in),   64'(vecs[i].exp_able));
    end

    // Broken valid pattern on empty, then a pop request skipping lane 0
    do_reset('0);
    cycle(3'b101, 3'b010);
    check("gap_push.count", 64'(count), 64'd1);
    cycle(3'b000, 3'b010);
    check("gap_pop.count",  64'(count), 64'd1);

    // Fill to 15, then one more push takes only lane 0
    do_reset('0);
    repeat (5) cycle(3'b111, 3'b000);
    check("fill15.count",   64'(count),   64'd15);
    check("fill15.able_in", 64'(able_in), 64'b001);
    cycle(3'b111, 3'b000);
    check("full.count",     64'(count),     64'd16);
    check("full.able_in",   64'(able_in),   64'b000);
    check("full.valid_out", 64'(valid_out), 64'b111);

    // Full with simultaneous push and pop: push dropped, two popped
    cycle(3'b111, 3'b011);
    check("full_pop.count", 64'(count), 64'd14);
    check_model("full_pop");

    // Reset in the middle of traffic
    cycle(3'b011, 3'b001);
    do_reset(3'b111);
    check("midreset.count",     64'(count),     64'd0);
    check("midreset.valid_out", 64'(valid_out), 64'b000);
    cycle(3'b111, 3'b000);
    check("after_reset.count", 64'(count), 64'd3);

    // Random stream with phases biased toward filling or draining
    begin
      bit flushed = 1'b0;
      for (int c = 0; c < 2000; c++) begin
        logic [WAYS-1:0] vin, rdy;
`ifdef FIFO_NWAY_FLUSH_EN
        if (!flushed && exp_q.size() == 7) begin
          flushed   = 1'b1;
          flush     = 1'b1;
          valid_in  = '1;
          ready_out = '1;
          @(posedge clk);
          #1;
          flush     = 1'b0;
          valid_in  = '0;
          ready_out = '0;
          exp_q.delete();
          exp_pop_val = next_data;
          check("flush.count", 64'(count), 64'd0);
        end
`endif
        if (((c / 200) % 2) == 0) begin
          vin = rand_lanes(20, WAYS);
          rdy = rand_lanes(20, 2);
        end else begin
          vin = rand_lanes(20, 2);
          rdy = rand_lanes(20, WAYS);
        end
        cycle(vin, rdy);
      end
      if (flushed) check_model("post_flush");
    end
    check_model("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
